maq_h: RTL
==========

MAQ_H -- requirements
Module: maq_h

Interface
REQ-001 SHALL have port maqh_clock, input, 1 bit: single system clock; all state updates on rising edge.
REQ-002 SHALL have port maqh_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port maqh_enable, input, 1 bit: clock-running enable, the same signal fed to the minute stage.
REQ-004 SHALL have port maqh_incremento, input, 1 bit: one-cycle seconds-rollover strobe, the same strobe fed to the minute stage.
REQ-005 SHALL have port maqh_incrementa_hora, input, 1 bit: level from the minute stage, high while minutes read 59.
REQ-006 SHALL have port maqh_ajuste, input, 1 bit: debounced, synchronous manual hour-set button level.
REQ-007 SHALL have port maqh_lsd, output, 4 bits: BCD hour units digit.
REQ-008 SHALL have port maqh_msd, output, 2 bits: BCD hour tens digit.
REQ-009 SHALL have port maqh_pm, output, 1 bit: PM flag.
REQ-010 SHALL have port maqh_incrementa_dia, output, 1 bit: one-cycle day-rollover pulse.

Function
REQ-011 SHALL define tick = maqh_enable & maqh_incremento & maqh_incrementa_hora; on tick, advance hour by one on the same edge the minute stage wraps 59->00.
REQ-012 SHALL register maqh_ajuste every cycle and define ajuste_pulso = maqh_ajuste & ~ajuste_prev (rising edge), independent of maqh_enable.
REQ-013 SHALL advance hour by exactly one when tick or ajuste_pulso is high; both high in the same cycle SHALL advance by one only.
REQ-014 SHALL, in 24 h mode, count 00..23: lsd 9->0 with msd+1; 23->00 wraps lsd and msd to 0.
REQ-015 SHALL hold lsd/msd unchanged when no advance occurs.
REQ-016 SHALL, on a 23->00 wrap (12 h mode: 11 PM->12 AM) caused by tick, assert maqh_incrementa_dia for exactly one cycle, starting the cycle after the wrap edge.
REQ-017 SHALL NOT assert maqh_incrementa_dia on a wrap caused by ajuste_pulso alone.
REQ-018 SHALL never produce lsd>9, lsd>3 when msd=2, or msd>2; an illegal state SHALL recover to reset value on next advance.

Reset
REQ-019 SHALL, on maqh_reset_n low, immediately clear ajuste_prev and maqh_incrementa_dia to 0.
REQ-020 SHALL, on maqh_reset_n low, set hour to 00 (24 h) or 12 AM (12 h: msd=1, lsd=2), with maqh_pm=0.
REQ-021 SHALL, when reset asserts mid-pulse, drop maqh_incrementa_dia at once; after release, the first advance SHALL require a new tick or a new rising edge of maqh_ajuste.

Configuration
REQ-022 SHALL, with macro MAQH_MODO_12H_EN defined, count 12,01..11,12 and toggle maqh_pm on the 11->12 advance.
REQ-023 SHALL, without MAQH_MODO_12H_EN, count 00..23 and tie maqh_pm to constant 0; port list identical in both builds.

Structure
REQ-024 SHALL take constants HORA_MAX_24 (23), HORA_MAX_12 (12), HORA_MIN_12 (1) and a BCD hour struct typedef from shared package relogio_pkg.
REQ-025 SHALL place rising-edge detection in sub-module maqh_detector_borda (in, clock, reset_n -> pulse).

Verification
REQ-026 SHALL check reset: drive maqh_reset_n=0 mid-count -> msd=0, lsd=0, pm=0, incrementa_dia=0 asynchronously (12 h build: msd=1, lsd=2).
REQ-027 SHALL check units carry: hour 09, enable=1, incrementa_hora=1, one incremento strobe -> hour 10 next edge, no dia pulse.
REQ-028 SHALL check day rollover: hour 23, one tick -> hour 00 and incrementa_dia high for exactly one cycle, one cycle after the wrap edge.
REQ-029 SHALL check ajuste: hold maqh_ajuste high 50 cycles at hour 23 with enable=0 -> single advance to 00, incrementa_dia stays 0.
REQ-030 SHALL check simultaneity: tick and ajuste rising edge in the same cycle at hour 05 -> hour 06, not 07.
REQ-031 SHALL check 12 h build: 11 AM + tick -> 12 PM (pm=1); 11 PM + tick -> 12 AM, pm=0, dia pulse.

Source files
------------

// File: rtl/relogio_pkg.sv
// Shared definitions for the clock stages: hour limits, the BCD hour type
// and the BCD constants derived from them.
package relogio_pkg;

    typedef struct packed {
        logic [1:0] msd;
        logic [3:0] lsd;
    } hora_bcd_t;

    localparam int HORA_MAX_24 = 23;
    localparam int HORA_MAX_12 = 12;
    localparam int HORA_MIN_12 = 1;

    localparam logic [3:0] LSD_MAX = 4'd9;

    function automatic hora_bcd_t bcd_de_int(input int valor);
        hora_bcd_t resultado;
        resultado.msd = 2'(valor / 10);
        resultado.lsd = 4'(valor % 10);
        return resultado;
    endfunction

    localparam hora_bcd_t HORA_ZERO_BCD     = bcd_de_int(0);
    localparam hora_bcd_t HORA_MAX_24_BCD   = bcd_de_int(HORA_MAX_24);
    localparam hora_bcd_t HORA_MAX_12_BCD   = bcd_de_int(HORA_MAX_12);
    localparam hora_bcd_t HORA_MIN_12_BCD   = bcd_de_int(HORA_MIN_12);
    localparam hora_bcd_t HORA_ANTES_12_BCD = bcd_de_int(HORA_MAX_12 - 1);

endpackage

// File: rtl/maqh_detector_borda.sv
// Rising-edge detector: one-cycle pulse on the first cycle the input is high.
module maqh_detector_borda (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_in,
    output logic o_pulse
);

    logic r_prev;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_in;
        end
    end

    assign o_pulse = i_in & ~r_prev;

endmodule

// File: rtl/maq_h.sv
// Hour stage of the clock: BCD hour counter advanced by the minute rollover
// or the manual set button. Define MAQH_MODO_12H_EN for the 12 h AM/PM build.
module maq_h
    import relogio_pkg::*;
(
    input  logic       maqh_clock,
    input  logic       maqh_reset_n,
    input  logic       maqh_enable,
    input  logic       maqh_incremento,
    input  logic       maqh_incrementa_hora,
    input  logic       maqh_ajuste,
    output logic [3:0] maqh_lsd,
    output logic [1:0] maqh_msd,
    output logic       maqh_pm,
    output logic       maqh_incrementa_dia
);

    hora_bcd_t r_hora;
    hora_bcd_t w_hora_prox;
    logic      r_dia;
    logic      w_tick;
    logic      w_ajuste_pulso;
    logic      w_avanca;
    logic      w_wrap;
    logic      w_ilegal;

    maqh_detector_borda u_detector_borda (
        .i_clock   (maqh_clock),
        .i_reset_n (maqh_reset_n),
        .i_in      (maqh_ajuste),
        .o_pulse   (w_ajuste_pulso)
    );

    assign w_tick   = maqh_enable & maqh_incremento & maqh_incrementa_hora;
    assign w_avanca = w_tick | w_ajuste_pulso;

`ifdef MAQH_MODO_12H_EN

    logic r_pm;
    logic w_pm_prox;

    assign w_ilegal = (r_hora.lsd > LSD_MAX)
                    || (r_hora.msd > HORA_MAX_12_BCD.msd)
                    || ((r_hora.msd == HORA_MAX_12_BCD.msd) && (r_hora.lsd > HORA_MAX_12_BCD.lsd))
                    || ((r_hora.msd == HORA_ZERO_BCD.msd) && (r_hora.lsd < HORA_MIN_12_BCD.lsd));

    // The day ends when 11 PM rolls to 12 AM, i.e. on the 11->12 step while PM is set.
    always_comb begin
        w_hora_prox = r_hora;
        w_pm_prox   = r_pm;
        w_wrap      = 1'b0;
        if (w_avanca) begin
            if (w_ilegal) begin
                w_hora_prox = HORA_MAX_12_BCD;
                w_pm_prox   = 1'b0;
            end else if (r_hora == HORA_MAX_12_BCD) begin
                w_hora_prox = HORA_MIN_12_BCD;
            end else if (r_hora == HORA_ANTES_12_BCD) begin
                w_hora_prox = HORA_MAX_12_BCD;
                w_pm_prox   = ~r_pm;
                w_wrap      = r_pm;
            end else if (r_hora.lsd == LSD_MAX) begin
                w_hora_prox.msd = r_hora.msd + 2'd1;
                w_hora_prox.lsd = 4'd0;
            end else begin
                w_hora_prox.lsd = r_hora.lsd + 4'd1;
            end
        end
    end

    always_ff @(posedge maqh_clock or negedge maqh_reset_n) begin
        if (!maqh_reset_n) begin
            r_hora <= HORA_MAX_12_BCD;
            r_pm   <= 1'b0;
            r_dia  <= 1'b0;
        end else begin
            r_hora <= w_hora_prox;
            r_pm   <= w_pm_prox;
            r_dia  <= w_tick & w_wrap;
        end
    end

    assign maqh_pm = r_pm;

`else

    assign w_ilegal = (r_hora.lsd > LSD_MAX)
                    || (r_hora.msd > HORA_MAX_24_BCD.msd)
                    || ((r_hora.msd == HORA_MAX_24_BCD.msd) && (r_hora.lsd > HORA_MAX_24_BCD.lsd));

    always_comb begin
        w_hora_prox = r_hora;
        w_wrap      = 1'b0;
        if (w_avanca) begin
            if (w_ilegal) begin
                w_hora_prox = HORA_ZERO_BCD;
            end else if (r_hora == HORA_MAX_24_BCD) begin
                w_hora_prox = HORA_ZERO_BCD;
                w_wrap      = 1'b1;
            end else if (r_hora.lsd == LSD_MAX) begin
                w_hora_prox.msd = r_hora.msd + 2'd1;
                w_hora_prox.lsd = 4'd0;
            end else begin
                w_hora_prox.lsd = r_hora.lsd + 4'd1;
            end
        end
    end

    // Only a minute-driven wrap ends the day; a manual set through midnight does not.
    always_ff @(posedge maqh_clock or negedge maqh_reset_n) begin
        if (!maqh_reset_n) begin
            r_hora <= HORA_ZERO_BCD;
            r_dia  <= 1'b0;
        end else begin
            r_hora <= w_hora_prox;
            r_dia  <= w_tick & w_wrap;
        end
    end

    assign maqh_pm = 1'b0;

`endif

    assign maqh_lsd            = r_hora.lsd;
    assign maqh_msd            = r_hora.msd;
    assign maqh_incrementa_dia = r_dia;

endmodule
